// File: rtl/gpu_pkg.sv
// Shared types and defaults for the gpu program loader slice.
// The loader FSM and its RUN timer both import this package.
package gpu_pkg;

  localparam int DATA_DEPTH_DEF  = 1024;
  localparam int WORD_W_DEF      = 16;
  localparam int RUN_TIMEOUT_DEF = 65535;

  localparam logic [WORD_W_DEF-1:0] ZERO_WORD = '0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } loader_state_t;

endpackage

// File: rtl/gpu_run_timer.sv
// RUN supervision timer: down-counter loaded on clear, terminal-count flags expiry.
// A RUN_TIMEOUT of 0 disables expiry entirely.
module gpu_run_timer
  import gpu_pkg::*;
#(
  parameter int RUN_TIMEOUT = RUN_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT) : 1;
  localparam logic [TW-1:0] LOAD_VAL = TW'((RUN_TIMEOUT > 0) ? RUN_TIMEOUT - 1 : 0);
  localparam bit TMO_EN = (RUN_TIMEOUT != 0);

  logic [TW-1:0] cnt;

  // Loaded with TIMEOUT-1 so terminal count lands on the last allowed RUN cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= LOAD_VAL;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = TMO_EN && enable && (cnt == '0);

endmodule

// File: rtl/gpu_prog_loader.sv
// Word-serial program loader: streams instructions into imem, zero-fills the tail,
// then releases the core and supervises the run until done or timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | core held in load mode, waiting for start
// ST_LOAD  | accepting stream words, one registered imem write each
// ST_CLEAR | zero-filling from wr_ptr to DATA_DEPTH-1
// ST_RUN   | prog_loading low, waiting for gpu_done or timeout
// ST_DONE  | run finished, core back in load mode, start reloads
module gpu_prog_loader
  import gpu_pkg::*;
#(
  parameter int DATA_DEPTH  = DATA_DEPTH_DEF,
  parameter int ADDR_W      = $clog2(DATA_DEPTH),
  parameter int WORD_W      = WORD_W_DEF,
  parameter int RUN_TIMEOUT = RUN_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              prog_loading,
  input  logic              gpu_done,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   prog_len,
  output logic              err_overflow,
  output logic              err_timeout
);

  localparam logic [ADDR_W:0] LAST_PTR  = (ADDR_W+1)'(DATA_DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_PTR = (ADDR_W+1)'(DATA_DEPTH);

  loader_state_t   state;
  logic [ADDR_W:0] wr_ptr;
  logic            accept;
  logic            tmr_expired;

  // Nothing is consumed on a cycle that abort or reset will discard.
  assign in_ready     = (state == ST_LOAD) && !abort && !reset;
  assign accept       = in_valid && in_ready;
  assign prog_loading = (state != ST_RUN);
  assign busy         = (state == ST_LOAD) || (state == ST_CLEAR) || (state == ST_RUN);
  assign done         = (state == ST_DONE);

  gpu_run_timer #(
    .RUN_TIMEOUT(RUN_TIMEOUT)
  ) u_run_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != ST_RUN),
    .enable (state == ST_RUN),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      wr_ptr       <= '0;
      prog_len     <= '0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
    end else begin
      imem_we <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              state        <= ST_LOAD;
              wr_ptr       <= '0;
              prog_len     <= '0;
              err_overflow <= 1'b0;
              err_timeout  <= 1'b0;
            end
          end
          ST_LOAD: begin
            if (accept) begin
              imem_we    <= 1'b1;
              imem_addr  <= wr_ptr[ADDR_W-1:0];
              imem_wdata <= in_data;
              wr_ptr     <= wr_ptr + 1'b1;
              prog_len   <= prog_len + 1'b1;
              if (in_last) begin
                state <= ST_CLEAR;
              end else if (wr_ptr == LAST_PTR) begin
                err_overflow <= 1'b1;
                state        <= ST_CLEAR;
              end
            end
          end
          // Exit only once the pointer has passed the top, so the final write lands before RUN.
          ST_CLEAR: begin
            if (wr_ptr == DEPTH_PTR) begin
              state <= ST_RUN;
            end else begin
              imem_we    <= 1'b1;
              imem_addr  <= wr_ptr[ADDR_W-1:0];
              imem_wdata <= WORD_W'(ZERO_WORD);
              wr_ptr     <= wr_ptr + 1'b1;
            end
          end
          ST_RUN: begin
            if (gpu_done) begin
              state <= ST_DONE;
            end else if (tmr_expired) begin
              state       <= ST_DONE;
              err_timeout <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
